// File: rtl/osc_meter_pkg.sv
// Shared definitions for the oscillator mux/frequency meter: FSM state
// encoding and the synchroniser flush length.
package osc_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DONE
  } meter_state_e;

  localparam int unsigned SETTLE_CYCLES = 3;

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchroniser for one asynchronous oscillator line, followed by a
// rising-edge detector on the synchronised value.
module osc_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/osc_mux_meter.sv
// Selects one of N_CH ring-oscillator outputs onto a pad and counts its
// rising edges over a programmable gate window of clock cycles.
module osc_mux_meter
  import osc_meter_pkg::*;
#(
  parameter int N_CH  = 16,
  parameter int SEL_W = $clog2(N_CH),
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [N_CH-1:0]  data_in,
  input  logic [SEL_W-1:0] select,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  output logic             y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int NPAD = 1 << SEL_W;
  localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  meter_state_e     state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [1:0]       settle_q, settle_d;
  logic [WIN_W-1:0] meas_q, meas_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [NPAD-1:0]  padded;
  logic             rise;
  logic             accept;

  // Unused select codes index zero-filled positions, so y reads 0 for them.
  always_comb begin
    padded = '0;
    padded[N_CH-1:0] = data_in;
  end

  assign y = padded[sel_q];

  osc_edge_sync u_sync (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .async_i(y),
    .rise_o (rise)
  );

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    win_d    = win_q;
    settle_d = settle_q;
    meas_d   = meas_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d  = SETTLE;
          sel_d    = select;
          win_d    = window;
          settle_d = '0;
          count_d  = '0;
          ovf_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          if (win_q != '0) begin
            state_d = MEASURE;
            meas_d  = win_q - WIN_W'(1);
          end else begin
            state_d = DONE;
          end
        end else begin
          settle_d = settle_q + 2'd1;
        end
      end
      MEASURE: begin
        if (rise) begin
          if (count_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        // meas_q holds the number of window cycles left after this one.
        if (meas_q == '0) begin
          state_d = DONE;
        end else begin
          meas_d = meas_q - WIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      win_q    <= '0;
      settle_q <= '0;
      meas_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      win_q    <= win_d;
      settle_q <= settle_d;
      meas_q   <= meas_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == SETTLE) || (state_q == MEASURE);
  assign done     = (state_q == DONE);
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_osc_mux_meter.sv
// Directed self-checking bench for osc_mux_meter: a default instance, a
// 4-bit-count instance for saturation and a 12-channel instance for
// out-of-range selects, all sharing one clock and reset.
module tb_osc_mux_meter;
  import osc_meter_pkg::*;

  logic        clock;
  logic        reset;
  logic        osc2;
  logic        osc4;
  logic [15:0] dataIn;
  logic [11:0] dataIn12;
  logic [3:0]  selectIn;
  logic [15:0] windowIn;
  logic        startMain, start4, start12;

  logic        yMain, busyMain, doneMain, ovfMain;
  logic [15:0] countMain;
  logic        y4, busy4, done4, ovf4;
  logic [3:0]  count4;
  logic        y12, busy12, done12, ovf12;
  logic [15:0] count12;

  int checkCount;
  int failCount;
  int lat;
  int doneSeen;

  assign dataIn   = {10'b0, osc4, 1'b0, osc2, 3'b0};
  assign dataIn12 = {12{osc2}};

  osc_mux_meter dutMain (
    .wb_clk_i(clock), .wb_rst_i(reset), .data_in(dataIn), .select(selectIn),
    .start(startMain), .window(windowIn), .y(yMain), .busy(busyMain),
    .done(doneMain), .count(countMain), .overflow(ovfMain)
  );

  osc_mux_meter #(.CNT_W(4)) dut4 (
    .wb_clk_i(clock), .wb_rst_i(reset), .data_in(dataIn), .select(selectIn),
    .start(start4), .window(windowIn), .y(y4), .busy(busy4),
    .done(done4), .count(count4), .overflow(ovf4)
  );

  osc_mux_meter #(.N_CH(12)) dut12 (
    .wb_clk_i(clock), .wb_rst_i(reset), .data_in(dataIn12), .select(selectIn),
    .start(start12), .window(windowIn), .y(y12), .busy(busy12),
    .done(done12), .count(count12), .overflow(ovf12)
  );

  // 10 ns clock; oscillators toggle every 4 and every 2 clocks, offset
  // from the clock edges.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    osc4 = 1'b0;
    forever #40 osc4 = ~osc4;
  end

  initial begin
    osc2 = 1'b0;
    forever #20 osc2 = ~osc2;
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Pulses start on one instance for one cycle (cycle 0); returns at the
  // falling edge of cycle 1.
  task automatic applyStimulus(input int which, input logic [3:0] sel,
                               input logic [15:0] win);
    @(negedge clock);
    selectIn = sel;
    windowIn = win;
    startMain = (which == 0);
    start4    = (which == 1);
    start12   = (which == 2);
    @(negedge clock);
    startMain = 1'b0;
    start4    = 1'b0;
    start12   = 1'b0;
  endtask

  function automatic logic doneOf(input int which);
    case (which)
      0:       return doneMain;
      1:       return done4;
      default: return done12;
    endcase
  endfunction

  // Counts cycles since start until done is seen, with a bounded budget.
  task automatic waitDone(input int which, input int fromCycle, output int cycles);
    cycles = fromCycle;
    while (!doneOf(which) && cycles < 300) begin
      @(negedge clock);
      cycles++;
    end
    if (cycles >= 300) checkOutput("doneTimeout", 32'(cycles), 32'd0);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    reset      = 1'b1;
    startMain  = 1'b0;
    start4     = 1'b0;
    start12    = 1'b0;
    selectIn   = '0;
    windowIn   = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    checkOutput("resetBusy",  32'(busyMain),  32'd0);
    checkOutput("resetDone",  32'(doneMain),  32'd0);
    checkOutput("resetCount", 32'(countMain), 32'd0);
    checkOutput("resetOvf",   32'(ovfMain),   32'd0);
    checkOutput("resetY",     32'(yMain),     32'd0);

    // Channel 5, toggle every 4 clocks, 64-cycle window.
    applyStimulus(0, 4'd5, 16'd64);
    checkOutput("busyInSettle", 32'(busyMain), 32'd1);
    waitDone(0, 1, lat);
    checkOutput("latency64", 32'(lat), 32'd68);
    checkOutput("count64", 32'(countMain), 32'd8);
    checkOutput("ovf64", 32'(ovfMain), 32'd0);
    checkOutput("busyInDone", 32'(busyMain), 32'd0);
    @(negedge clock);
    checkOutput("donePulseOneCycle", 32'(doneMain), 32'd0);
    checkOutput("countHeld", 32'(countMain), 32'd8);

    // Zero-length window: straight from SETTLE to DONE.
    applyStimulus(0, 4'd5, 16'd0);
    waitDone(0, 1, lat);
    checkOutput("latencyWin0", 32'(lat), 32'd4);
    checkOutput("countWin0", 32'(countMain), 32'd0);

    // A second start while measuring must be ignored.
    applyStimulus(0, 4'd5, 16'd64);
    repeat (10) @(negedge clock);
    applyStimulus(0, 4'd3, 16'd8);
    checkOutput("yFollowsFirst", 32'(yMain), 32'(osc4));
    checkOutput("busyAfterIgnored", 32'(busyMain), 32'd1);
    waitDone(0, 13, lat);
    checkOutput("latencyIgnored", 32'(lat), 32'd68);
    checkOutput("countIgnored", 32'(countMain), 32'd8);
    @(negedge clock);

    // Saturation with a 4-bit counter: 25 edges in 100 cycles.
    applyStimulus(1, 4'd3, 16'd100);
    waitDone(1, 1, lat);
    checkOutput("latencySat", 32'(lat), 32'd104);
    checkOutput("countSat", 32'(count4), 32'd15);
    checkOutput("ovfSat", 32'(ovf4), 32'd1);
    @(negedge clock);
    checkOutput("ovfSticky", 32'(ovf4), 32'd1);

    // Out-of-range select on the 12-channel instance.
    applyStimulus(2, 4'd13, 16'd20);
    checkOutput("yOutOfRange", 32'(y12), 32'd0);
    waitDone(2, 1, lat);
    checkOutput("latencyOutOfRange", 32'(lat), 32'd24);
    checkOutput("countOutOfRange", 32'(count12), 32'd0);
    @(negedge clock);

    // Reset in the middle of MEASURE.
    applyStimulus(0, 4'd5, 16'd64);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midResetBusy", 32'(busyMain), 32'd0);
    checkOutput("midResetCount", 32'(countMain), 32'd0);
    checkOutput("midResetDone", 32'(doneMain), 32'd0);
    checkOutput("midResetState", 32'(dutMain.state_q), 32'(IDLE));
    doneSeen = 0;
    repeat (80) begin
      @(negedge clock);
      if (doneMain) doneSeen++;
    end
    checkOutput("noDoneAfterReset", 32'(doneSeen), 32'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule
